flag_ctrl: RTL
==============

Name: flag_ctrl

Overview:
Writer side of the per-level flag arrays that the board redraw path reads. It takes right-click events from the mouse path and converts the pointer position to a board cell (column, row) using iterative subtraction, so no divider is needed. It then toggles the flag at that cell under a flag-budget limit and presents the easy, medium and hard flag arrays plus a remaining-flag count to the draw and game-logic blocks.

Parameters:
MAX_DIM, 16, largest board dimension in cells (hard level); sizes the iteration guard.
POS_W, 12, width of the mouse and board pixel coordinates.

Ports:
clk  in  1  system clock
rst  in  1  reset
mouse_xpos  in  POS_W  pointer x, pixels
mouse_ypos  in  POS_W  pointer y, pixels
right_btn  in  1  right mouse button level, already synchronous to clk
board_xpos  in  11  board top-left x, pixels
board_ypos  in  11  board top-left y, pixels
button_size  in  8  cell edge length, pixels
button_num  in  5  cells per side (8 easy, 10 medium, 16 hard)
level  in  2  1=easy, 2=medium, 3=hard, 0=no game
mines  in  8  flag budget for the current game
new_game  in  1  one-cycle pulse; clears all flags and reloads the budget
game_active  in  1  flagging allowed only when high
revealed  in  256  bit (col*16+row) high = cell already uncovered
flag_arr_easy  out  [7:0][7:0]  flag map indexed [col][row], 0-based
flag_arr_medium  out  [9:0][9:0]  flag map indexed [col][row], 0-based
flag_arr_hard  out  [15:0][15:0]  flag map indexed [col][row], 0-based
flags_left  out  8  remaining budget
flag_event  out  1  one-cycle pulse when a flag is placed or removed
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: rst is synchronous and active-high on clk. It clears all three arrays, sets flags_left=0, flag_event=0, busy=0, FSM=IDLE and the button edge register to 0. An rst in any state aborts the operation with no array change.
- Edge detection: a click is right_btn rising (registered previous level 0, current level 1).
  - A click is accepted only in IDLE with game_active=1 and level!=0.
  - Clicks arriving in any other state are dropped, not queued.
- IDLE:
  - On an accepted click, latch dx = mouse_xpos - board_xpos and dy = mouse_ypos - board_ypos, clear col and row, then go to CALC.
  - If mouse_xpos < board_xpos, mouse_ypos < board_ypos, or button_size == 0, stay in IDLE with no effect.
- CALC, one iteration per cycle, x and y in parallel:
  - If dx >= button_size: dx -= button_size and col += 1. The same rule applies to dy and row.
  - When both remainders are below button_size, go to CHECK.
  - If col or row reaches button_num, or the iteration count reaches MAX_DIM, abort to IDLE. This covers clicks right of or below the board.
- CHECK, one cycle. Select target = array[level][col][row]. The cell is blocked if revealed[col*16+row] = 1.
  - If blocked: go to IDLE with no change.
  - If the target is set: go to UPDATE as a removal.
  - If the target is clear and flags_left == 0: go to IDLE with no change.
  - Otherwise: go to UPDATE as a placement.
- UPDATE, one cycle:
  - Write the target bit in the array selected by level only; the other arrays are untouched.
  - Placement: flags_left -= 1. Removal: flags_left += 1.
  - Assert flag_event for this cycle, then return to IDLE.
- Latency: from the cycle right_btn is first sampled high, arrays and flags_left update at 3 + max(col,row) cycles. The edge register takes 1 cycle, then CALC, CHECK and UPDATE follow.
- new_game:
  - Clears all three arrays, sets flags_left = mines, and forces IDLE.
  - It has priority over any in-flight operation in the same cycle.
  - No flag_event is produced.
- game_active falling mid-operation: the operation completes normally. The gate applies only at click acceptance.
- flags_left never underflows below 0 and never exceeds mines. A removal always corresponds to an earlier placement.
- Arithmetic: dx and dy are POS_W unsigned, compared unsigned, with subtraction done only after the lower-bound check. col and row are 5 bits. Array index bits above button_num-1 are never written.

Test Plan:
- Easy setup (board 100,100; size 40; num 8; mines 10; new_game), click at (185,230) -> col 2, row 3; flag_arr_easy[2][3]=1, flags_left=9, flag_event pulse once, latency 6 cycles.
- Repeat the same click after release -> flag_arr_easy[2][3]=0, flags_left=10.
- Hard setup (size 30, num 16, mines 2): flag three distinct cells -> first two set with flags_left=0; third leaves the array unchanged with no flag_event.
- Click at (99,150) and at (100+8*40,150) on easy -> no change, busy returns low within at most 9 cycles.
- revealed bit for (1,1) set, click on cell (1,1) -> no flag, no event. Second click while busy -> ignored.
- Place flags, then pulse new_game mid-CALC with mines=15 -> all arrays zero, flags_left=15, FSM IDLE. Also assert rst mid-CALC -> all outputs reset.

Source files
------------

// File: rtl/flag_ctrl.sv
// flag_ctrl
//
// Writer side of the per-level flag maps read by the board redraw path.
// A right-click is turned into a board cell (col, row) by repeatedly
// subtracting the cell size from the pointer offset, one step per cycle
// on both axes at once. The flag at that cell is then toggled, subject to
// the remaining flag budget and to the cell not being uncovered.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   mouse_xpos, mouse_ypos   pointer position in pixels (POS_W bits)
//   right_btn                right button level, already synchronous to clk
//   board_xpos, board_ypos   board top-left corner in pixels
//   button_size              cell edge length in pixels
//   button_num               cells per side (8 / 10 / 16)
//   level                    1 easy, 2 medium, 3 hard, 0 no game
//   mines                    flag budget loaded by new_game
//   new_game                 pulse: clear every map, reload the budget
//   game_active              clicks are accepted only while high
//   revealed                 bit col*16+row set = cell already uncovered
//   flag_arr_easy/medium/hard  flag maps indexed [col][row]
//   flags_left               remaining flag budget
//   flag_event               one-cycle pulse when a flag is placed/removed
//   busy                     high while a click is being processed

module flag_ctrl #(
    parameter int MAX_DIM = 16,
    parameter int POS_W   = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [POS_W-1:0]        mouse_xpos,
    input  logic [POS_W-1:0]        mouse_ypos,
    input  logic                    right_btn,
    input  logic [10:0]             board_xpos,
    input  logic [10:0]             board_ypos,
    input  logic [7:0]              button_size,
    input  logic [4:0]              button_num,
    input  logic [1:0]              level,
    input  logic [7:0]              mines,
    input  logic                    new_game,
    input  logic                    game_active,
    input  logic [255:0]            revealed,
    output logic [7:0][7:0]         flag_arr_easy,
    output logic [9:0][9:0]         flag_arr_medium,
    output logic [15:0][15:0]       flag_arr_hard,
    output logic [7:0]              flags_left,
    output logic                    flag_event,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        CHECK,
        UPDATE
    } state_t;

    // A legitimate cell never needs more than MAX_DIM-1 subtraction steps,
    // so reaching MAX_DIM steps means the pointer is off the board.
    localparam logic [5:0] MAX_ITER = 6'(MAX_DIM);

    state_t state, state_next;

    logic             btn_prev;
    logic             click;
    logic [POS_W-1:0] dx, dy;
    logic [POS_W-1:0] size_ext, board_x_ext, board_y_ext;
    logic [4:0]       col, row, col_inc, row_inc;
    logic [5:0]       iter, iter_inc;
    logic             x_more, y_more;
    logic             accept, step_x, step_y, do_update;
    logic             in_range, target, blocked;

    assign click       = right_btn & ~btn_prev;
    assign size_ext    = POS_W'(button_size);
    assign board_x_ext = POS_W'(board_xpos);
    assign board_y_ext = POS_W'(board_ypos);
    assign x_more      = (dx >= size_ext);
    assign y_more      = (dy >= size_ext);
    assign col_inc     = col + 5'd1;
    assign row_inc     = row + 5'd1;
    assign iter_inc    = iter + 6'd1;
    assign blocked     = revealed[{col[3:0], row[3:0]}];
    assign busy        = (state != IDLE);

    // Look up the current flag bit at (col,row) in the map chosen by level.
    // in_range guards against a cell that lies outside that map, so nothing
    // beyond the level's own dimensions is ever read or written.
    always_comb begin
        in_range = 1'b0;
        target   = 1'b0;
        case (level)
            2'd1: begin
                if (col < 5'd8 && row < 5'd8) begin
                    in_range = 1'b1;
                    target   = flag_arr_easy[col[2:0]][row[2:0]];
                end
            end
            2'd2: begin
                if (col < 5'd10 && row < 5'd10) begin
                    in_range = 1'b1;
                    target   = flag_arr_medium[col[3:0]][row[3:0]];
                end
            end
            2'd3: begin
                if (col < 5'd16 && row < 5'd16) begin
                    in_range = 1'b1;
                    target   = flag_arr_hard[col[3:0]][row[3:0]];
                end
            end
            default: begin
                in_range = 1'b0;
                target   = 1'b0;
            end
        endcase
    end

    // State register. new_game forcing IDLE is handled in the next-state
    // logic so that it also suppresses the datapath strobes below.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the datapath strobes. The step strobes are
    // only raised when the step is safe; an increment that would land on
    // button_num (click right of / below the board) aborts instead.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step_x     = 1'b0;
        step_y     = 1'b0;
        do_update  = 1'b0;
        case (state)
            IDLE: begin
                if (click && game_active && level != 2'd0 &&
                    mouse_xpos >= board_x_ext && mouse_ypos >= board_y_ext &&
                    button_size != 8'd0) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (col >= button_num || row >= button_num) begin
                    state_next = IDLE;
                end else if (x_more || y_more) begin
                    if ((x_more && col_inc >= button_num) ||
                        (y_more && row_inc >= button_num) ||
                        iter_inc >= MAX_ITER) begin
                        state_next = IDLE;
                    end else begin
                        step_x = x_more;
                        step_y = y_more;
                    end
                end else begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (!in_range || blocked) begin
                    state_next = IDLE;
                end else if (target) begin
                    state_next = UPDATE;
                end else if (flags_left == 8'd0) begin
                    state_next = IDLE;
                end else begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                do_update  = in_range;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (new_game) begin
            state_next = IDLE;
            accept     = 1'b0;
            step_x     = 1'b0;
            step_y     = 1'b0;
            do_update  = 1'b0;
        end
    end

    // Datapath: button edge register, the subtraction remainders and cell
    // counters, and the flag maps with their budget. UPDATE toggles the
    // bit found in CHECK: a set bit is a removal and returns one flag to
    // the budget, a clear bit is a placement and consumes one. CHECK only
    // lets a placement through when the budget is non-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev        <= 1'b0;
            dx              <= '0;
            dy              <= '0;
            col             <= '0;
            row             <= '0;
            iter            <= '0;
            flag_arr_easy   <= '0;
            flag_arr_medium <= '0;
            flag_arr_hard   <= '0;
            flags_left      <= '0;
            flag_event      <= 1'b0;
        end else begin
            btn_prev   <= right_btn;
            flag_event <= 1'b0;
            if (new_game) begin
                flag_arr_easy   <= '0;
                flag_arr_medium <= '0;
                flag_arr_hard   <= '0;
                flags_left      <= mines;
            end else begin
                if (accept) begin
                    dx   <= mouse_xpos - board_x_ext;
                    dy   <= mouse_ypos - board_y_ext;
                    col  <= '0;
                    row  <= '0;
                    iter <= '0;
                end else begin
                    if (step_x) begin
                        dx  <= dx - size_ext;
                        col <= col_inc;
                    end
                    if (step_y) begin
                        dy  <= dy - size_ext;
                        row <= row_inc;
                    end
                    if (step_x || step_y) begin
                        iter <= iter_inc;
                    end
                end
                if (do_update) begin
                    case (level)
                        2'd1:    flag_arr_easy[col[2:0]][row[2:0]]   <= ~target;
                        2'd2:    flag_arr_medium[col[3:0]][row[3:0]] <= ~target;
                        2'd3:    flag_arr_hard[col[3:0]][row[3:0]]   <= ~target;
                        default: ;
                    endcase
                    flags_left <= target ? (flags_left + 8'd1) : (flags_left - 8'd1);
                    flag_event <= 1'b1;
                end
            end
        end
    end

endmodule
